// File: rtl/tcp_vlg_pkg.sv
// rtl/tcp_vlg_pkg.sv - shared types and constants for the TCP keep-alive supervisor
package tcp_vlg_pkg;

  localparam int KA_PORT_W = 16;

  typedef enum logic [2:0] {
    KA_OFF   = 3'd0,
    KA_IDLE  = 3'd1,
    KA_PROBE = 3'd2,
    KA_WAIT  = 3'd3,
    KA_DCN   = 3'd4
  } tcp_ka_state_t;

  function automatic int ka_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcp_vlg_keepalive_if.sv
// rtl/tcp_vlg_keepalive_if.sv - rx segment metadata and probe handshake bundle
interface tcp_vlg_keepalive_if #(parameter int N_CONN = 4);
  import tcp_vlg_pkg::*;

  localparam int IDX_W = ka_idx_w(N_CONN);

  logic                 rx_val;
  logic [KA_PORT_W-1:0] rx_src_port;
  logic [KA_PORT_W-1:0] rx_dst_port;
  logic                 probe_req;
  logic [IDX_W-1:0]     probe_idx;
  logic                 probe_ack;

  // master is the keep-alive block, slave is the rx parser / tx engine side
  modport master (
    input  rx_val, rx_src_port, rx_dst_port, probe_ack,
    output probe_req, probe_idx
  );
  modport slave (
    output rx_val, rx_src_port, rx_dst_port, probe_ack,
    input  probe_req, probe_idx
  );
endinterface

// File: rtl/tcp_vlg_keepalive_ch.sv
// rtl/tcp_vlg_keepalive_ch.sv - keep-alive state machine for one connection
module tcp_vlg_keepalive_ch
  import tcp_vlg_pkg::*;
#(
  parameter int IDLE_TICKS     = 600000000,
  parameter int INTERVAL_TICKS = 125000000,
  parameter int TRIES          = 5,
  parameter int TMR_W          = 30,
  parameter int TRY_W          = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 con,
  input  logic                 rx_val,
  input  logic [KA_PORT_W-1:0] rx_src_port,
  input  logic [KA_PORT_W-1:0] rx_dst_port,
  input  logic [KA_PORT_W-1:0] loc_port,
  input  logic [KA_PORT_W-1:0] rem_port,
  input  logic                 grant,
  output logic                 probing,
  output logic                 dcn
);

  tcp_ka_state_t    state;
  logic [TMR_W-1:0] timer;
  logic [TRY_W-1:0] tries;
  logic             hit;

  assign hit = rx_val && (rx_dst_port == loc_port) && (rx_src_port == rem_port);

  always_ff @(posedge clk) begin
    if (rst || !con) begin
      state <= KA_OFF;
      timer <= '0;
      tries <= '0;
    end else begin
      case (state)
        KA_OFF: begin
          state <= KA_IDLE;
          timer <= '0;
          tries <= '0;
        end
        KA_IDLE: begin
          if (hit) begin
            timer <= '0;
          end else if (timer == TMR_W'(IDLE_TICKS - 1)) begin
            state <= KA_PROBE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        KA_PROBE: begin
          // a hit while queued still lets the probe go, but restarts the try count
          if (grant) begin
            state <= KA_WAIT;
            timer <= '0;
            tries <= (hit ? '0 : tries) + TRY_W'(1);
          end else if (hit) begin
            tries <= '0;
          end
        end
        KA_WAIT: begin
          if (hit) begin
            state <= KA_IDLE;
            timer <= '0;
            tries <= '0;
          end else if (timer == TMR_W'(INTERVAL_TICKS - 1)) begin
            state <= (tries == TRY_W'(TRIES)) ? KA_DCN : KA_PROBE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        KA_DCN: ;
        default: state <= KA_OFF;
      endcase
    end
  end

  // gated by con so a dropped link withdraws its request and dcn immediately
  assign probing = con && (state == KA_PROBE);
  assign dcn     = con && (state == KA_DCN);

endmodule

// File: rtl/tcp_vlg_keepalive.sv
// rtl/tcp_vlg_keepalive.sv - multi-connection TCP keep-alive with round-robin probe arbiter
module tcp_vlg_keepalive
  import tcp_vlg_pkg::*;
#(
  parameter int N_CONN         = 4,
  parameter int IDLE_TICKS     = 600000000,
  parameter int INTERVAL_TICKS = 125000000,
  parameter int TRIES          = 5,
  parameter int ENABLE         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CONN-1:0]           con,
  input  logic [N_CONN*KA_PORT_W-1:0] loc_port,
  input  logic [N_CONN*KA_PORT_W-1:0] rem_port,
  tcp_vlg_keepalive_if.master         ka,
  output logic [N_CONN-1:0]           dcn
);

  localparam int IDX_W   = ka_idx_w(N_CONN);
  localparam int TMR_MAX = (IDLE_TICKS > INTERVAL_TICKS) ? IDLE_TICKS : INTERVAL_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TRY_W   = $clog2(TRIES + 1);

  logic [N_CONN-1:0] probing;
  logic [N_CONN-1:0] grant;
  logic [N_CONN-1:0] dcn_raw;
  logic              req_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              req_out;
  logic              hs;

  assign req_out = (ENABLE != 0) && req_r && probing[idx_r];
  assign hs      = req_out && ka.probe_ack;

  for (genvar i = 0; i < N_CONN; i++) begin : g_ch
    assign grant[i] = hs && (idx_r == IDX_W'(i));

    tcp_vlg_keepalive_ch #(
      .IDLE_TICKS     (IDLE_TICKS),
      .INTERVAL_TICKS (INTERVAL_TICKS),
      .TRIES          (TRIES),
      .TMR_W          (TMR_W),
      .TRY_W          (TRY_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .con         (con[i]),
      .rx_val      (ka.rx_val),
      .rx_src_port (ka.rx_src_port),
      .rx_dst_port (ka.rx_dst_port),
      .loc_port    (loc_port[KA_PORT_W*i +: KA_PORT_W]),
      .rem_port    (rem_port[KA_PORT_W*i +: KA_PORT_W]),
      .grant       (grant[i]),
      .probing     (probing[i]),
      .dcn         (dcn_raw[i])
    );
  end

  always_comb begin : pick_p
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int k = 0; k < N_CONN; k++) begin
      j = (int'(rr_ptr) + k) % N_CONN;
      if (!pick_vld && probing[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  // the presented request is frozen until accepted or its channel disconnects
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r  <= 1'b0;
      idx_r  <= '0;
      rr_ptr <= '0;
    end else if (req_out) begin
      if (ka.probe_ack) begin
        req_r  <= 1'b0;
        rr_ptr <= (idx_r == IDX_W'(N_CONN - 1)) ? '0 : idx_r + IDX_W'(1);
      end
    end else begin
      req_r <= pick_vld;
      if (pick_vld) idx_r <= pick_idx;
    end
  end

  assign ka.probe_req = req_out;
  assign ka.probe_idx = (ENABLE != 0) ? idx_r : '0;
  assign dcn          = (ENABLE != 0) ? dcn_raw : '0;

endmodule

// File: tb/tb_tcp_vlg_keepalive.sv
// tb/tb_tcp_vlg_keepalive.sv - directed and randomized bench for tcp_vlg_keepalive
module tb_tcp_vlg_keepalive;

  localparam int N = 4, IDLE = 100, INTV = 20, TRIES = 3;
  localparam int S_OFF = 0, S_IDLE = 1, S_PROBE = 2, S_WAIT = 3, S_DCN = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    con;
  logic [N*16-1:0] loc_port, rem_port;
  logic [N-1:0]    dcn;

  tcp_vlg_keepalive_if #(.N_CONN(N)) ka();

  tcp_vlg_keepalive #(.N_CONN(N), .IDLE_TICKS(IDLE), .INTERVAL_TICKS(INTV),
                      .TRIES(TRIES), .ENABLE(1)) dut (
    .clk(clk), .rst(rst), .con(con), .loc_port(loc_port),
    .rem_port(rem_port), .ka(ka), .dcn(dcn));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int m_st[N], m_dl[N], m_tr[N], obs_hs[N];
  int m_req = 0, m_idx = 0, m_ptr = 0, cyc = 0;

  function automatic logic [15:0] lp(input int i); return 16'(32'h5000 + i * 7); endfunction
  function automatic logic [15:0] rp(input int i); return 16'(32'h8000 + i * 3); endfunction

  function automatic bit exp_req();
    return m_req != 0 && m_st[m_idx] == S_PROBE && con[m_idx] === 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: deadlines are absolute edge numbers; the model advances with each edge.
  task automatic cycle();
    bit hs, hit;
    int g, f, j;
    logic [N-1:0] ed;
    cyc++;
    hs = exp_req() && ka.probe_ack === 1'b1;
    g  = m_idx;
    if (ka.probe_req === 1'b1 && ka.probe_ack === 1'b1) obs_hs[ka.probe_idx]++;
    if (rst) begin
      m_req = 0; m_idx = 0; m_ptr = 0;
    end else if (exp_req()) begin
      if (hs) begin m_req = 0; m_ptr = (m_idx + 1) % N; end
    end else begin
      f = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (f < 0 && m_st[j] == S_PROBE && con[j]) f = j;
      end
      m_req = (f >= 0);
      if (f >= 0) m_idx = f;
    end
    for (int i = 0; i < N; i++) begin
      hit = ka.rx_val && ka.rx_dst_port == lp(i) && ka.rx_src_port == rp(i);
      if (rst || !con[i]) begin m_st[i] = S_OFF; m_tr[i] = 0; end
      else case (m_st[i])
        S_OFF:   begin m_st[i] = S_IDLE; m_dl[i] = cyc + IDLE; m_tr[i] = 0; end
        S_IDLE:  if (hit) m_dl[i] = cyc + IDLE; else if (cyc == m_dl[i]) m_st[i] = S_PROBE;
        S_PROBE: if (hs && g == i) begin
                   m_tr[i] = (hit ? 0 : m_tr[i]) + 1; m_st[i] = S_WAIT; m_dl[i] = cyc + INTV;
                 end else if (hit) m_tr[i] = 0;
        S_WAIT:  if (hit) begin m_st[i] = S_IDLE; m_dl[i] = cyc + IDLE; m_tr[i] = 0; end
                 else if (cyc == m_dl[i]) m_st[i] = (m_tr[i] == TRIES) ? S_DCN : S_PROBE;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    ed = '0;
    for (int i = 0; i < N; i++) ed[i] = (m_st[i] == S_DCN) && con[i];
    chk("probe_req", ka.probe_req, exp_req());
    if (exp_req()) chk("probe_idx", ka.probe_idx, m_idx);
    chk("dcn", dcn, ed);
  endtask

  task automatic clear_hs();
    for (int i = 0; i < N; i++) obs_hs[i] = 0;
  endtask

  initial begin
    int k, lat, c;
    rst = 1'b1; con = '0;
    ka.rx_val = 1'b0; ka.rx_src_port = '0; ka.rx_dst_port = '0; ka.probe_ack = 1'b1;
    for (int i = 0; i < N; i++) begin
      loc_port[16*i +: 16] = lp(i); rem_port[16*i +: 16] = rp(i);
      m_st[i] = S_OFF; m_dl[i] = 0; m_tr[i] = 0; obs_hs[i] = 0;
    end
    repeat (3) cycle();
    chk("rst_probe_req", ka.probe_req, 0);
    chk("rst_probe_idx", ka.probe_idx, 0);
    chk("rst_dcn", dcn, 0);
    rst = 1'b0;

    // silent connection: three probes then disconnect
    con[0] = 1'b1; lat = 0;
    while (ka.probe_req !== 1'b1 && lat < 300) begin cycle(); lat++; end
    chk("first_probe_window", 32'(lat >= 100 && lat <= 103), 1);
    k = 0;
    while (dcn[0] !== 1'b1 && k < 200) begin cycle(); k++; end
    chk("dcn0_set", dcn[0], 1);
    chk("probes_before_dcn", obs_hs[0], 3);
    repeat (10) cycle();
    chk("dcn0_held", dcn[0], 1);
    chk("no_probe_in_dcn", obs_hs[0], 3);
    con[0] = 1'b0;
    #1;
    chk("dcn_drop_same_cycle", dcn[0], 0);
    cycle();

    // hit at cycle 50 delays the probe; hit in WAIT resets tries
    con[0] = 1'b1;
    repeat (50) cycle();
    ka.rx_val = 1'b1; ka.rx_src_port = rp(0); ka.rx_dst_port = lp(0);
    cycle();
    ka.rx_val = 1'b0; lat = 0;
    while (ka.probe_req !== 1'b1 && lat < 300) begin cycle(); lat++; end
    chk("probe_after_hit_window", 32'(lat >= 99 && lat <= 102), 1);
    k = 0;
    while (!(m_st[0] == S_WAIT && m_tr[0] == 2) && k < 200) begin cycle(); k++; end
    chk("reach_wait_two_tries", 32'(k < 200), 1);
    ka.rx_val = 1'b1;
    cycle();
    ka.rx_val = 1'b0;
    repeat (150) cycle();
    chk("no_dcn_after_wait_hit", dcn[0], 0);

    // simultaneous timeouts on channels 1 and 2 with a stalled tx engine
    con = '0; cycle();
    con[1] = 1'b1; con[2] = 1'b1; lat = 0;
    while (ka.probe_req !== 1'b1 && lat < 300) begin cycle(); lat++; end
    chk("arb_first_idx", ka.probe_idx, 1);
    ka.probe_ack = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      chk("stall_req_held", ka.probe_req, 1);
      chk("stall_idx_held", ka.probe_idx, 1);
    end
    ka.probe_ack = 1'b1;
    cycle();
    k = 0;
    while (ka.probe_req !== 1'b1 && k < 10) begin cycle(); k++; end
    chk("arb_next_idx", ka.probe_idx, 2);

    // channel 3 drops while waiting after two probes
    con = '0; cycle();
    con[3] = 1'b1; k = 0;
    while (!(m_st[3] == S_WAIT && m_tr[3] == 2) && k < 300) begin cycle(); k++; end
    chk("ch3_reach_wait", 32'(k < 300), 1);
    con[3] = 1'b0; clear_hs();
    repeat (250) cycle();
    chk("ch3_no_probe", obs_hs[3], 0);
    chk("ch3_no_dcn", dcn[3], 0);

    // non-matching rx traffic must not refresh the idle timer
    con = '0; cycle();
    con[0] = 1'b1; lat = 0;
    while (ka.probe_req !== 1'b1 && lat < 300) begin
      c = $urandom_range(0, 3);
      ka.rx_val = (c != 3);
      ka.rx_src_port = (c == 0) ? lp(0) : rp(1);
      ka.rx_dst_port = (c == 0) ? rp(0) : ((c == 1) ? lp(1) : lp(0));
      cycle(); lat++;
    end
    ka.rx_val = 1'b0;
    chk("noise_probe_window", 32'(lat >= 100 && lat <= 103), 1);

    // randomized traffic, link flaps and tx backpressure
    con = 4'b1111;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 199) == 0) begin
        c = $urandom_range(0, N - 1);
        con[c] = ~con[c];
      end
      ka.probe_ack = ($urandom_range(0, 3) != 0);
      ka.rx_val = ($urandom_range(0, 19) == 0);
      c = $urandom_range(0, N - 1);
      ka.rx_dst_port = lp(c);
      ka.rx_src_port = $urandom_range(0, 1) ? rp(c) : 16'($urandom);
      cycle();
    end
    ka.rx_val = 1'b0; ka.probe_ack = 1'b1;

    // reset with a pending probe and an active disconnect
    con = '0; cycle();
    con[0] = 1'b1; k = 0;
    while (dcn[0] !== 1'b1 && k < 400) begin cycle(); k++; end
    chk("pre_rst_dcn", dcn[0], 1);
    con[1] = 1'b1; ka.probe_ack = 1'b0; k = 0;
    while (ka.probe_req !== 1'b1 && k < 200) begin cycle(); k++; end
    chk("pre_rst_req", ka.probe_req, 1);
    rst = 1'b1;
    cycle();
    chk("rst_req_clear", ka.probe_req, 0);
    chk("rst_idx_clear", ka.probe_idx, 0);
    chk("rst_dcn_clear", dcn, 0);
    rst = 1'b0; ka.probe_ack = 1'b1; lat = 0;
    while (ka.probe_req !== 1'b1 && lat < 300) begin cycle(); lat++; end
    chk("recover_probe_window", 32'(lat >= 100 && lat <= 103), 1);
    chk("recover_idx", ka.probe_idx, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
